data_mem_ctrl: RTL and testbench

Parametrised, handshaked data memory for the RISC-V core's MEM stage. It replaces the single-cycle combinational-read memory with a byte-addressed RAM that supports a configurable read latency, little-endian byte ordering and the full RV32I load/store width set. It also detects misaligned, out-of-range and illegal accesses and reports them as errors to the trap logic. One request is outstanding at a time. Each request, load or store, receives exactly one response.

---
 rtl/data_mem_ctrl.sv | 119 +++++++++++
 tb/tb_data_mem_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed, little-endian data memory for the MEM stage with a fixed, configurable read latency.
// Accepts one request at a time and returns one response pulse per request, flagging misaligned, out-of-range or illegal accesses.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [31:0]       data_q;
  logic              err_q;
  logic              accept;

  logic [1:0]        size_m1;
  logic [ADDR_W:0]   end_addr;
  logic              misaligned, out_of_range, bad_f3, req_err;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word, load_ext;

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  assign accept = req_valid && req_ready;
  assign idx    = req_addr[IDX_W-1:0];

  // Request decode: access size, legality and little-endian load formatting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    size_m1 = 2'd3;
    case (req_funct3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    // One extra bit keeps addr + size - 1 from wrapping past the top of the address space.
    end_addr     = {1'b0, req_addr} + (ADDR_W+1)'(size_m1);
    out_of_range = (end_addr >= DEPTH_EXT);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    bad_f3       = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                          : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    req_err      = misaligned || out_of_range || bad_f3;

    rd_word = {mem[idx + IDX_W'(3)], mem[idx + IDX_W'(2)],
               mem[idx + IDX_W'(1)], mem[idx]};
    case (req_funct3)
      3'b000:  load_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  load_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  load_ext = {24'h0, rd_word[7:0]};
      3'b101:  load_ext = {16'h0, rd_word[15:0]};
      default: load_ext = rd_word;
    endcase
  end

  // NOTE: storage has no reset; committed bytes survive rst and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (b <= int'(size_m1)) mem[idx + IDX_W'(b)] <= req_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      data_q <= 32'h0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= 4'(LATENCY - 1);
      data_q <= (req_err || req_we) ? 32'h0 : load_ext;
      err_q  <= req_err;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response fields are forced to zero outside the response pulse.
  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = (state == S_RESP);
    resp_rdata = resp_valid ? data_q : 32'h0;
    resp_err   = resp_valid && err_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance at LATENCY=1 for data/error behaviour,
// one at LATENCY=4 for handshake timing and reset during an outstanding request.
module tb_data_mem_ctrl;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic        valid1, ready1, we1, rvalid1, rerr1;
  logic [2:0]  f3_1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        valid4, ready4, we4, rvalid4, rerr4;
  logic [2:0]  f3_4;
  logic [31:0] addr4, wdata4, rdata4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1), .req_we(we1),
    .req_funct3(f3_1), .req_addr(addr1), .req_wdata(wdata1),
    .resp_valid(rvalid1), .resp_rdata(rdata1), .resp_err(rerr1)
  );

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(valid4), .req_ready(ready4), .req_we(we4),
    .req_funct3(f3_4), .req_addr(addr4), .req_wdata(wdata4),
    .resp_valid(rvalid4), .resp_rdata(rdata4), .resp_err(rerr4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=1 instance; the response must follow in the very next cycle.
  task automatic req1(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    valid1 = 1'b1; we1 = we; f3_1 = f3; addr1 = addr; wdata1 = wdata;
    check({tag, " ready"}, 32'(ready1), 32'd1);
    @(negedge clk);
    valid1 = 1'b0;
    check({tag, " valid"}, 32'(rvalid1), 32'd1);
    check({tag, " rdata"}, rdata1, exp_data);
    check({tag, " err"}, 32'(rerr1), 32'(exp_err));
  endtask

  // Issue a request on the LATENCY=4 instance and expect the response on the 4th cycle only.
  task automatic req4(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_data);
    @(negedge clk);
    valid4 = 1'b1; we4 = we; f3_4 = 3'b010; addr4 = addr; wdata4 = wdata;
    check({tag, " ready"}, 32'(ready4), 32'd1);
    @(negedge clk);
    valid4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("%s valid c%0d", tag, c), 32'(rvalid4), 32'(c == 4));
    end
    check({tag, " rdata"}, rdata4, exp_data);
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    valid1 = 1'b0; we1 = 1'b0; f3_1 = 3'b010; addr1 = '0; wdata1 = '0;
    valid4 = 1'b0; we4 = 1'b0; f3_4 = 3'b010; addr4 = '0; wdata4 = '0;

    // Reset held for 3 cycles, ready low throughout, then high once rst falls.
    repeat (3) begin
      @(negedge clk);
      check("rst ready", 32'(ready1), 32'd0);
    end
    rst1 = 1'b0; rst4 = 1'b0;
    #1;
    check("post-rst ready", 32'(ready1), 32'd1);
    check("post-rst valid", 32'(rvalid1), 32'd0);
    check("post-rst rdata", rdata1, 32'h0);
    check("post-rst err", 32'(rerr1), 32'd0);
    check("post-rst ready4", 32'(ready4), 32'd1);

    // Word store then all load widths.
    req1("SW 10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req1("LW 10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    req1("LB 10", 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    req1("LBU 13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    req1("LH 12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    req1("LHU 10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);

    // Partial stores touch only their bytes.
    req1("SB 11", 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0);
    req1("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    req1("SH 12", 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
    req1("LW after SH", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    // Faulting accesses; none may disturb memory.
    req1("LW 12 misal", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    req1("LW chk1", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    req1("SH 11 misal", 1'b1, 3'b001, 32'h11, 32'hFFFFAAAA, 32'h0, 1'b1);
    req1("LW chk2", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    req1("SW top-2", 1'b1, 3'b010, 32'(DEPTH - 2), 32'hCAFEF00D, 32'h0, 1'b1);
    req1("LW chk3", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    req1("LD f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    req1("LW chk4", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    req1("ST f3=100", 1'b1, 3'b100, 32'h10, 32'h11111111, 32'h0, 1'b1);
    req1("LW chk5", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    req1("SH top-1", 1'b1, 3'b001, 32'(DEPTH - 1), 32'h0, 32'h0, 1'b1);
    req1("LB wrap", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);
    req1("LW top-4", 1'b0, 3'b010, 32'(DEPTH - 4), 32'h0, 32'h0, 1'b0);
    req1("SB top-1", 1'b1, 3'b000, 32'(DEPTH - 1), 32'h00000080, 32'h0, 1'b0);
    req1("LB top-1", 1'b0, 3'b000, 32'(DEPTH - 1), 32'h0, 32'hFFFFFF80, 1'b0);

    // LATENCY=4 handshake: req_valid stays high while busy, next accept in cycle 5.
    @(negedge clk);
    valid4 = 1'b1; we4 = 1'b1; f3_4 = 3'b010; addr4 = 32'h40; wdata4 = 32'h11223344;
    check("L4 c0 ready", 32'(ready4), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      we4 = 1'b0; addr4 = 32'h40;
      check($sformatf("L4 c%0d ready", c), 32'(ready4), 32'd0);
      check($sformatf("L4 c%0d valid", c), 32'(rvalid4), 32'(c == 4));
    end
    @(negedge clk);
    check("L4 c5 ready", 32'(ready4), 32'd1);
    check("L4 c5 valid", 32'(rvalid4), 32'd0);
    @(negedge clk);
    valid4 = 1'b0;
    check("L4 c6 ready", 32'(ready4), 32'd0);
    repeat (3) @(negedge clk);
    check("L4 2nd valid", 32'(rvalid4), 32'd1);
    check("L4 2nd rdata", rdata4, 32'h11223344);
    check("L4 2nd err", 32'(rerr4), 32'd0);

    // Reset during an outstanding store: bytes stay, response is dropped.
    @(negedge clk);
    valid4 = 1'b1; we4 = 1'b1; addr4 = 32'h20; wdata4 = 32'hA5A5A5A5;
    check("midrst ready", 32'(ready4), 32'd1);
    @(negedge clk);
    valid4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("midrst no valid %0d", c), 32'(rvalid4), 32'd0);
      @(negedge clk);
    end
    req4("midrst LW 20", 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
